// File: rtl/reg_dump_if.sv
// Bundle of request and serial-output signals of the register dump path.
// Ports: start, regs_flat (to serializer); tx, busy, done, reg_idx (from serializer).
interface reg_dump_if #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
    logic                    start;
    logic [NUM_REGS*4-1:0]   regs_flat;
    logic                    tx;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        reg_idx;

    modport master (
        output start, regs_flat,
        input  tx, busy, done, reg_idx
    );

    modport slave (
        input  start, regs_flat,
        output tx, busy, done, reg_idx
    );
endinterface

// File: rtl/reg_dump_serializer.sv
// Snapshots NUM_REGS 4-bit registers on start and shifts them out as
// 6-bit UART-style frames (start, 4 data LSB first, stop) on bus.tx.
// Ports: clk, rst_n (async active-low), bus (slave side of reg_dump_if).
module reg_dump_serializer #(
    parameter int NUM_REGS     = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_dump_if.slave  bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            bit_q, bit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_REGS*4-1:0] shadow_q, shadow_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [3:0]            nib;

    assign nib = shadow_q[{idx_q, 2'b00} +: 4];

    // tx is computed for the state being entered so it stays a pure flop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.start) begin
                shadow_d = bus.regs_flat;
                idx_d    = '0;
                cnt_d    = '0;
                bit_d    = '0;
                state_d  = S_START;
                busy_d   = 1'b1;
                tx_d     = 1'b0;
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            unique case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = 2'd0;
                    tx_d    = nib[0];
                end
                S_DATA: begin
                    if (bit_q == 2'd3) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 2'd1;
                        tx_d  = nib[bit_q + 2'd1];
                    end
                end
                S_STOP: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_q + 1'b1;
                        tx_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.reg_idx = idx_q;
endmodule
